// File: rtl/memshare_ibram_remap_loader_pkg.sv
// Shared configuration for the IB-RAM remap loader: geometry, widths and loader state type.
package memshare_ibram_remap_loader_pkg;

   localparam int unsigned SHARE_GROUP_SIZE      = 4;
   localparam int unsigned QUAN_SIZE             = 4;
   localparam int unsigned ROW_NUM               = 8;
   localparam int unsigned ROW_ADDR_WIDTH        = $clog2(ROW_NUM);
   localparam int unsigned COL_NUM               = 4;
   localparam int unsigned COL_SEL_WIDTH         = 2;
   localparam int unsigned COL_CNT_WIDTH         = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
   localparam int unsigned IBRAM_REMAP_VEC_WIDTH = QUAN_SIZE * SHARE_GROUP_SIZE;
   localparam int unsigned RANK_COL_ADDR_WIDTH   = COL_SEL_WIDTH * SHARE_GROUP_SIZE;
   localparam int unsigned LOAD_WORDS            = ROW_NUM * COL_NUM;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/memshare_ibram_remap_loader_addr_cnt.sv
// Row/column write-address counter for the remap loader; rows advance first, columns on row wrap.
module memshare_remap_addr_cnt
   import memshare_ibram_remap_loader_pkg::*;
(
   input  logic                      write_clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      inc,
   output logic [ROW_ADDR_WIDTH-1:0] row_cnt,
   output logic [COL_CNT_WIDTH-1:0]  col_cnt,
   output logic                      last_c
);

   logic row_wrap_c;
   logic col_wrap_c;

   assign row_wrap_c = (row_cnt == ROW_ADDR_WIDTH'(ROW_NUM - 1));
   assign col_wrap_c = (col_cnt == COL_CNT_WIDTH'(COL_NUM - 1));
   assign last_c     = row_wrap_c && col_wrap_c;

   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         row_cnt <= '0;
         col_cnt <= '0;
      end else if (clr) begin
         row_cnt <= '0;
         col_cnt <= '0;
      end else if (inc) begin
         if (row_wrap_c) begin
            row_cnt <= '0;
            col_cnt <= col_wrap_c ? '0 : COL_CNT_WIDTH'(col_cnt + COL_CNT_WIDTH'(1));
         end else begin
            row_cnt <= ROW_ADDR_WIDTH'(row_cnt + ROW_ADDR_WIDTH'(1));
         end
      end
   end

endmodule

// File: rtl/memshare_ibram_remap_loader.sv
// Streams IB-LUT page rows into the shared IB-RAM rank, column-major, and holds off
// rank reads while a reload is in flight.
module memshare_ibram_remap_loader
   import memshare_ibram_remap_loader_pkg::*;
(
   input  logic                             write_clk,
   input  logic                             rst,
   input  logic                             start_i,
   input  logic                             lut_valid_i,
   input  logic [IBRAM_REMAP_VEC_WIDTH-1:0] lut_data_i,
   output logic                             lut_ready_o,
   output logic [IBRAM_REMAP_VEC_WIDTH-1:0] remap_dataIn_vec_o,
   output logic [ROW_ADDR_WIDTH-1:0]        remap_rowAddr_o,
   output logic [RANK_COL_ADDR_WIDTH-1:0]   memShare_colSel_vec_o,
   output logic                             nRemap_en_o,
   output logic                             rank_rd_hold_o,
   output logic                             done_o,
   output logic                             busy_o
);

   loader_state_e state_q;
   loader_state_e state_d;

   logic                      xfer_c;
   logic                      cnt_clr_c;
   logic                      last_c;
   logic                      ready_d;
   logic                      busy_d;
   logic                      hold_d;
   logic                      done_d;
   logic [ROW_ADDR_WIDTH-1:0] row_cnt;
   logic [COL_CNT_WIDTH-1:0]  col_cnt;

   // ready is only ever high in LOAD, so it doubles as the accept qualifier
   assign xfer_c = lut_valid_i && lut_ready_o;

   memshare_remap_addr_cnt u_addr_cnt (
      .write_clk (write_clk),
      .rst       (rst),
      .clr       (cnt_clr_c),
      .inc       (xfer_c),
      .row_cnt   (row_cnt),
      .col_cnt   (col_cnt),
      .last_c    (last_c)
   );

   // Next-state and next-value of the registered status outputs
   always_comb begin
      state_d   = state_q;
      cnt_clr_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_LOAD;
               cnt_clr_c = 1'b1;
            end
         end
         ST_LOAD: begin
            if (xfer_c && last_c) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_LOAD);
      busy_d  = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
      hold_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write port and status registers; address/data only move on an accepted word
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         lut_ready_o           <= 1'b0;
         busy_o                <= 1'b0;
         rank_rd_hold_o        <= 1'b0;
         done_o                <= 1'b0;
         nRemap_en_o           <= 1'b1;
         remap_dataIn_vec_o    <= '0;
         remap_rowAddr_o       <= '0;
         memShare_colSel_vec_o <= '0;
      end else begin
         lut_ready_o    <= ready_d;
         busy_o         <= busy_d;
         rank_rd_hold_o <= hold_d;
         done_o         <= done_d;
         nRemap_en_o    <= ~xfer_c;
         if (xfer_c) begin
            remap_dataIn_vec_o    <= lut_data_i;
            remap_rowAddr_o       <= row_cnt;
            memShare_colSel_vec_o <= {SHARE_GROUP_SIZE{COL_SEL_WIDTH'(col_cnt)}};
         end
      end
   end

endmodule

// File: tb/tb_memshare_ibram_remap_loader.sv
// Randomized bench for the IB-RAM remap loader against a word-count based reference model.
module tb_memshare_ibram_remap_loader;
   import memshare_ibram_remap_loader_pkg::*;

   logic                             write_clk = 1'b0;
   logic                             rst;
   logic                             start_i;
   logic                             lut_valid_i;
   logic [IBRAM_REMAP_VEC_WIDTH-1:0] lut_data_i;
   logic                             lut_ready_o;
   logic [IBRAM_REMAP_VEC_WIDTH-1:0] remap_dataIn_vec_o;
   logic [ROW_ADDR_WIDTH-1:0]        remap_rowAddr_o;
   logic [RANK_COL_ADDR_WIDTH-1:0]   memShare_colSel_vec_o;
   logic                             nRemap_en_o;
   logic                             rank_rd_hold_o;
   logic                             done_o;
   logic                             busy_o;

   memshare_ibram_remap_loader dut (
      .write_clk             (write_clk),
      .rst                   (rst),
      .start_i               (start_i),
      .lut_valid_i           (lut_valid_i),
      .lut_data_i            (lut_data_i),
      .lut_ready_o           (lut_ready_o),
      .remap_dataIn_vec_o    (remap_dataIn_vec_o),
      .remap_rowAddr_o       (remap_rowAddr_o),
      .memShare_colSel_vec_o (memShare_colSel_vec_o),
      .nRemap_en_o           (nRemap_en_o),
      .rank_rd_hold_o        (rank_rd_hold_o),
      .done_o                (done_o),
      .busy_o                (busy_o)
   );

   always #5 write_clk = ~write_clk;

   int checks = 0;
   int errors = 0;
   int dut_strobes = 0;

   // Reference model: words accepted so far and cycles elapsed since the last word
   bit                               m_loading;
   int                               m_words;
   int                               m_post;
   bit                               m_wrote;
   logic [IBRAM_REMAP_VEC_WIDTH-1:0] m_data;
   int                               m_row;
   int                               m_col;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] colsel_of(input int col);
      logic [31:0] v = '0;
      for (int k = 0; k < SHARE_GROUP_SIZE; k++) v = v | (32'(col) << (k * COL_SEL_WIDTH));
      return v;
   endfunction

   function automatic logic [IBRAM_REMAP_VEC_WIDTH-1:0] rep_word(input int idx);
      logic [IBRAM_REMAP_VEC_WIDTH-1:0] v = '0;
      for (int k = 0; k < SHARE_GROUP_SIZE; k++)
         v = v | (IBRAM_REMAP_VEC_WIDTH'(idx % (1 << QUAN_SIZE)) << (k * QUAN_SIZE));
      return v;
   endfunction

   task automatic model_reset();
      m_loading = 1'b0;
      m_words   = 0;
      m_post    = 0;
      m_wrote   = 1'b0;
      m_data    = '0;
      m_row     = 0;
      m_col     = 0;
   endtask

   task automatic compare_all();
      check("ready", 32'(lut_ready_o), 32'(m_loading));
      check("busy", 32'(busy_o), 32'(m_loading || m_post == 1));
      check("hold", 32'(rank_rd_hold_o), 32'(m_loading || m_post != 0));
      check("done", 32'(done_o), 32'(m_post == 2));
      check("n_strobe", 32'(nRemap_en_o), 32'(!m_wrote));
      check("data", 32'(remap_dataIn_vec_o), 32'(m_data));
      check("row", 32'(remap_rowAddr_o), 32'(m_row));
      check("colsel", 32'(memShare_colSel_vec_o), colsel_of(m_col));
   endtask

   // One clock: apply inputs, advance the model by the rules, compare after the edge
   task automatic step(input bit st, input bit vld, input logic [IBRAM_REMAP_VEC_WIDTH-1:0] d);
      start_i     = st;
      lut_valid_i = vld;
      lut_data_i  = d;
      @(posedge write_clk);
      #1;
      m_wrote = 1'b0;
      if (m_loading) begin
         if (vld) begin
            m_wrote = 1'b1;
            m_data  = d;
            m_row   = m_words % ROW_NUM;
            m_col   = m_words / ROW_NUM;
            m_words++;
            if (m_words == LOAD_WORDS) begin
               m_loading = 1'b0;
               m_post    = 1;
            end
         end
      end else if (m_post != 0) begin
         m_post = (m_post == 2) ? 0 : m_post + 1;
      end else if (st) begin
         m_loading = 1'b1;
         m_words   = 0;
      end
      if (nRemap_en_o == 1'b0) dut_strobes++;
      compare_all();
      if (m_wrote && m_col == 2 && m_row == 0)
         check("colsel_col2", 32'(memShare_colSel_vec_o), 32'h0000_00AA);
      start_i     = 1'b0;
      lut_valid_i = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge write_clk);
      #1;
      rst = 1'b0;
   endtask

   // Drive words until the model reports the page complete; bounded by a cycle budget
   task automatic finish_load(input int valid_pct, input bit rand_data);
      int budget = 2000;
      int base   = dut_strobes;
      int need   = LOAD_WORDS - m_words;
      while (m_loading && budget > 0) begin
         bit v = ($urandom_range(99) < valid_pct);
         step(($urandom_range(7) == 0), v, rand_data ? IBRAM_REMAP_VEC_WIDTH'($urandom) : rep_word(m_words));
         budget--;
      end
      if (budget == 0) check("load_timeout", 32'(m_loading), 32'd0);
      check("strobe_count", 32'(dut_strobes - base), 32'(need));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
   endtask

   initial begin
      start_i     = 1'b0;
      lut_valid_i = 1'b0;
      lut_data_i  = '0;
      model_reset();
      apply_reset();

      // Idle with stray valid words and no start
      for (int i = 0; i < 10; i++) step(1'b0, (i % 3 == 0), IBRAM_REMAP_VEC_WIDTH'($urandom));

      // Continuous load, data = word index replicated
      step(1'b1, 1'b0, '0);
      finish_load(100, 1'b0);

      // Valid toggling 1/0
      step(1'b1, 1'b0, '0);
      for (int c = 0; c < 2 * LOAD_WORDS + 4 && m_loading; c++)
         step(1'b0, (c % 2 == 0), rep_word(m_words));
      check("toggle_complete", 32'(m_loading), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

      // Second start during LOAD after word 5 must be ignored
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rep_word(i));
      step(1'b1, 1'b1, rep_word(5));
      check("restart_row", 32'(remap_rowAddr_o), 32'd5);
      step(1'b0, 1'b1, rep_word(6));
      check("restart_row_next", 32'(remap_rowAddr_o), 32'd6);
      finish_load(100, 1'b0);

      // Reset after word 12, then a fresh load begins at (0,0)
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, rep_word(i));
      apply_reset();
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, rep_word(0));
      check("post_rst_row0", 32'(remap_rowAddr_o), 32'd0);
      finish_load(100, 1'b0);

      // Randomized loads with gaps, random data and stray starts
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < int'($urandom_range(5)); i++)
            step(1'b0, 1'($urandom_range(1)), IBRAM_REMAP_VEC_WIDTH'($urandom));
         step(1'b1, 1'($urandom_range(1)), IBRAM_REMAP_VEC_WIDTH'($urandom));
         finish_load(40 + 15 * n, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
